// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//
// Digit-serial adder/subtractor. Computes A+B or A-B over WIDTH bits, DIGIT
// bits per clock, through one carry-chained DIGIT-bit adder. A complete flag
// set (carry, signed overflow, zero, negative) is captured with the result.
//
// Handshakes (both directions): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and result/flags hold stable until out_ready is seen.
// Both ready/valid outputs are decoded from the state register only.
//
// Optional feature: define ADDSUB_SAT_EN to clamp an overflowing result to
// the most positive / most negative two's-complement value.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand request          in_ready   operands accepted (IDLE)
//   op         0 = add, 1 = subtract    a, b       operands
//   out_valid  result valid (held)      out_ready  consumer accepts result
//   result     sum / difference         cout       carry out (sub: 1 = no borrow)
//   overflow   signed overflow          zero       result == 0
//   negative   result MSB               dbg_state  FSM state (IDLE/RUN/DONE)
// ---------------------------------------------------------------------------
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;        // operand A, shifted right one digit per cycle
  logic [WIDTH-1:0] bx_q;       // effective operand (b or ~b), shifted likewise
  logic [WIDTH-1:0] acc_q;      // partial result, digits enter from the top
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;    // MSBs latched at accept for the overflow test
  logic             bx_msb_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  // Digit adder and next-state values
  logic [DIGIT:0]         dsum_d;
  logic [WIDTH+DIGIT-1:0] acc_cat_d;
  logic [WIDTH-1:0]       acc_d;
  logic [WIDTH-1:0]       final_d;
  logic                   ovf_d;
  logic                   last_d;

  always_comb begin
    dsum_d    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, bx_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    // New digit goes in at the top, older digits move down one slot.
    acc_cat_d = {dsum_d[DIGIT-1:0], acc_q};
    acc_d     = acc_cat_d[WIDTH+DIGIT-1:DIGIT];
    last_d    = (cnt_q == CW'(NDIG - 1));
    // Signed overflow: operands share a sign that the result does not.
    ovf_d     = (a_msb_q == bx_msb_q) && (dsum_d[DIGIT-1] != a_msb_q);
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      final_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_d = acc_d;
    end
`else
    final_d   = acc_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      bx_q       <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      bx_msb_q   <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            bx_q     <= op ? ~b : b;
            carry_q  <= op;       // +1 completes the two's complement of b
            cnt_q    <= '0;
            acc_q    <= '0;
            a_msb_q  <= a[WIDTH-1];
            bx_msb_q <= op ? ~b[WIDTH-1] : b[WIDTH-1];
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          a_q     <= a_q >> DIGIT;
          bx_q    <= bx_q >> DIGIT;
          carry_q <= dsum_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            result_q   <= final_d;
            cout_q     <= dsum_d[DIGIT];
            overflow_q <= ovf_d;
            zero_q     <= (final_d == '0);
            negative_q <= final_d[WIDTH-1];
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 8-bit (defaults) ----------------
  logic        iv8 = 1'b0, op8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, co8, of8, z8, n8;
  logic [7:0]  r8;
  logic [1:0]  st8;

  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(r8),
    .cout(co8), .overflow(of8), .zero(z8), .negative(n8), .dbg_state(st8)
  );

  // ---------------- DUT 16-bit ----------------
  logic        iv16 = 1'b0, op16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, co16, of16, z16, n16;
  logic [15:0] r16;
  logic [1:0]  st16;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(r16),
    .cout(co16), .overflow(of16), .zero(z16), .negative(n16), .dbg_state(st16)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {result[15:0], cout, overflow, zero, negative} for width w.
  function automatic logic [19:0] model(input int w, input logic op,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] mask, bx, full;
    logic [15:0] res;
    logic        c, v;
    mask = (17'd1 << w) - 17'd1;
    bx   = op ? (~{1'b0, b} & mask) : {1'b0, b};
    full = {1'b0, a} + bx + {16'd0, op};
    res  = full[15:0] & mask[15:0];
    c    = full[w];
    v    = (a[w-1] == bx[w-1]) && (res[w-1] != a[w-1]);
    if (SAT && v) res = a[w-1] ? (16'd1 << (w-1)) : ((16'd1 << (w-1)) - 16'd1);
    return {res, c, v, (res == 16'd0), res[w-1]};
  endfunction

  // ---------------- driver tasks ----------------
  // Accept one operation and wait (bounded) for out_valid; leaves DUT in DONE.
  task automatic run8(input logic op, input logic [7:0] ai, input logic [7:0] bi,
                      output int lat);
    @(negedge clk);
    iv8 = 1'b1; op8 = op; a8 = ai; b8 = bi;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8;
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
  endtask

  task automatic run16(input logic op, input logic [15:0] ai, input logic [15:0] bi,
                       output int lat);
    @(negedge clk);
    iv16 = 1'b1; op16 = op; a16 = ai; b16 = bi;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release16;
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1; or16 = 1'b0;
  endtask

  // Check all 8-bit outputs against {res, cout, ovf, zero, neg}.
  task automatic chk8(input string tag, input logic [7:0] res, input logic c,
                      input logic v, input logic z, input logic n);
    chk({tag, "_valid"}, {31'd0, ov8}, 32'd1);
    chk({tag, "_res"},   {24'd0, r8},  {24'd0, res});
    chk({tag, "_flags"}, {28'd0, co8, of8, z8, n8}, {28'd0, c, v, z, n});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [19:0] e;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rop;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, ir8}, 32'd1);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_result",    {24'd0, r8},  32'd0);
    chk("rst_flags",     {28'd0, co8, of8, z8, n8}, 32'd0);
    chk("rst_in_ready16", {31'd0, ir16}, 32'd1);

    // 0x05 - 0x03 = 0x02, latency 2
    run8(1'b1, 8'h05, 8'h03, lat);
    chk("sub_05_03_lat", lat, 32'd2);
    chk8("sub_05_03", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_in_ready", {31'd0, ir8}, 32'd0);

    // backpressure: hold out_ready low, offer a new operand meanwhile
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = 1'b1; op8 = 1'b0; a8 = 8'hAA; b8 = 8'h11;
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, ir8}, 32'd0);
      chk8("bp_hold", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); iv8 = 1'b0;
    release8();
    chk("bp_released_in_ready", {31'd0, ir8}, 32'd1);
    chk("bp_released_valid",    {31'd0, ov8}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept", {31'd0, ov8}, 32'd0);

    // 0x03 - 0x05 = 0xFE, borrow
    run8(1'b1, 8'h03, 8'h05, lat);
    chk8("sub_03_05", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    release8();

    // 0x10 - 0x10 = 0x00
    run8(1'b1, 8'h10, 8'h10, lat);
    chk8("sub_10_10", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    release8();

    // 0xFF + 0x01 wraps to 0x00
    run8(1'b0, 8'hFF, 8'h01, lat);
    chk8("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    release8();

    // 0x7F + 0x01 overflows positive
    run8(1'b0, 8'h7F, 8'h01, lat);
    if (SAT) chk8("add_7f_01", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    else     chk8("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    release8();

    // 0x80 - 0x01 overflows negative
    run8(1'b1, 8'h80, 8'h01, lat);
    chk("sub_80_01_lat", lat, 32'd2);
    if (SAT) chk8("sub_80_01", 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
    else     chk8("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    release8();

    // reset mid-RUN: outputs were non-zero from the previous operation
    @(negedge clk);
    iv8 = 1'b1; op8 = 1'b0; a8 = 8'h33; b8 = 8'h44;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    chk("midrun_state", {30'd0, st8}, 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrun_rst_valid",  {31'd0, ov8}, 32'd0);
    chk("midrun_rst_result", {24'd0, r8},  32'd0);
    chk("midrun_rst_flags",  {28'd0, co8, of8, z8, n8}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrun_rel_in_ready", {31'd0, ir8}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_discarded", {31'd0, ov8}, 32'd0);
    run8(1'b0, 8'h01, 8'h01, lat);
    chk8("post_rst_add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    release8();

    // 16-bit: 0xFFFF + 0x0001, latency 4
    run16(1'b0, 16'hFFFF, 16'h0001, lat);
    chk("w16_lat", lat, 32'd4);
    chk("w16_valid", {31'd0, ov16}, 32'd1);
    chk("w16_res",   {16'd0, r16}, 32'd0);
    chk("w16_flags", {28'd0, co16, of16, z16, n16}, {28'd0, 4'b1010});
    release16();

    // random vectors against the reference model
    for (int i = 0; i < 600; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      exp_q.push_back(model(8, rop, {8'd0, ra}, {8'd0, rb}));
      run8(rop, ra, rb, lat);
      e = exp_q.pop_front();
      chk("rnd8_lat", lat, 32'd2);
      chk("rnd8_out", {12'd0, 8'd0, r8, co8, of8, z8, n8}, {12'd0, e});
      release8();
    end
    for (int i = 0; i < 300; i++) begin
      rop = 1'($urandom_range(0, 1));
      wa  = 16'($urandom_range(0, 65535));
      wb  = 16'($urandom_range(0, 65535));
      exp_q.push_back(model(16, rop, wa, wb));
      run16(rop, wa, wb, lat);
      e = exp_q.pop_front();
      chk("rnd16_lat", lat, 32'd4);
      chk("rnd16_out", {12'd0, r16, co16, of16, z16, n16}, {12'd0, e});
      release16();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
